// File: rtl/laser_dac_spi.sv
// Galvo point output stage: serialises X/Y to a dual 12-bit SPI DAC,
// pulses LDAC so both axes move together, drives laser colour and
// blanks the laser when the point stream stalls.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   pt_x/pt_y       : 12-bit coordinates (DAC channel A / B)
//   pt_rgb          : laser colour {r,g,b}, 1 = on
//   pt_valid/ready  : point handshake
//   dac_csn/sclk/mosi/latchn : DAC serial bus and LDAC
//   laser_rgb       : laser drive, active high
//   wdog_blank      : 1 while the stall watchdog forces the laser off
//   pts_sent        : completed point count, wraps
module laser_dac_spi #(
  parameter int          CLK_DIV  = 2,
  parameter int          CS_GAP   = 2,
  parameter int          LATCH_W  = 2,
  parameter logic        DAC_BUF  = 1'b0,
  parameter logic        DAC_GA_N = 1'b1,
  parameter int          WDOG_CYC = 50000,
  // reset value of pts_sent
  parameter logic [15:0] PTS_RST  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pt_x,
  input  logic [11:0] pt_y,
  input  logic [2:0]  pt_rgb,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic        dac_csn,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_latchn,
  output logic [2:0]  laser_rgb,
  output logic        wdog_blank,
  output logic [15:0] pts_sent
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT_A = 3'd1;
  localparam logic [2:0] S_GAP_A   = 3'd2;
  localparam logic [2:0] S_SHIFT_B = 3'd3;
  localparam logic [2:0] S_GAP_B   = 3'd4;
  localparam logic [2:0] S_LATCH   = 3'd5;

  localparam int CM0  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CMAX = (CM0 > LATCH_W) ? CM0 : LATCH_W;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int WW   = $clog2(WDOG_CYC + 1);

  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] LAT_END = CW'(LATCH_W - 1);
  localparam logic [WW-1:0] WD_END  = WW'(WDOG_CYC);

  // frame control nibble: {ch, BUF, GA_n, SHDN_n}
  localparam logic [3:0] HDR_A = {1'b0, DAC_BUF, DAC_GA_N, 1'b1};
  localparam logic [3:0] HDR_B = {1'b1, DAC_BUF, DAC_GA_N, 1'b1};

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   sh_q, sh_d;
  logic [11:0]   y_q, y_d;
  logic [2:0]    rgb_q, rgb_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          ready_q, ready_d;
  logic          csn_q, csn_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          latchn_q, latchn_d;
  logic [2:0]    laser_q, laser_d;
  logic          blank_q, blank_d;
  logic [15:0]   pts_q, pts_d;

  logic        accept;
  logic [15:0] frame_a;
  logic [15:0] frame_b;

  assign accept  = pt_valid & ready_q;
  assign frame_a = {HDR_A, pt_x};
  assign frame_b = {HDR_B, y_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    y_d      = y_q;
    rgb_d    = rgb_q;
    wdog_d   = wdog_q;
    ready_d  = ready_q;
    csn_d    = csn_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    latchn_d = latchn_q;
    laser_d  = laser_q;
    blank_d  = blank_q;
    pts_d    = pts_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // X goes straight into the shifter; Y waits for frame B
          y_d     = pt_y;
          rgb_d   = pt_rgb;
          sh_d    = frame_a;
          mosi_d  = frame_a[15];
          bit_d   = 4'd15;
          cnt_d   = '0;
          csn_d   = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
          wdog_d  = '0;
          state_d = S_SHIFT_A;
        end else if (wdog_q == WD_END) begin
          laser_d = 3'b000;
          blank_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      S_SHIFT_A, S_SHIFT_B: begin
        if (cnt_q == DIV_END) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            sclk_d  = 1'b0;
            csn_d   = 1'b1;
            state_d = (state_q == S_SHIFT_A) ?
                      S_GAP_A : S_GAP_B;
          end else begin
            // next bit presented on the falling edge
            sclk_d = 1'b0;
            bit_d  = bit_q - 4'd1;
            sh_d   = {sh_q[14:0], 1'b0};
            mosi_d = sh_q[14];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP_A, S_GAP_B: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (state_q == S_GAP_A) begin
            sh_d    = frame_b;
            mosi_d  = frame_b[15];
            bit_d   = 4'd15;
            csn_d   = 1'b0;
            state_d = S_SHIFT_B;
          end else begin
            latchn_d = 1'b0;
            laser_d  = rgb_q;
            blank_d  = 1'b0;
            state_d  = S_LATCH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == LAT_END) begin
          cnt_d    = '0;
          latchn_d = 1'b1;
          ready_d  = 1'b1;
          pts_d    = pts_q + 16'd1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 4'd0;
      sh_q     <= 16'h0000;
      y_q      <= 12'h000;
      rgb_q    <= 3'b000;
      wdog_q   <= '0;
      ready_q  <= 1'b1;
      csn_q    <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      latchn_q <= 1'b1;
      laser_q  <= 3'b000;
      blank_q  <= 1'b0;
      pts_q    <= PTS_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      y_q      <= y_d;
      rgb_q    <= rgb_d;
      wdog_q   <= wdog_d;
      ready_q  <= ready_d;
      csn_q    <= csn_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      latchn_q <= latchn_d;
      laser_q  <= laser_d;
      blank_q  <= blank_d;
      pts_q    <= pts_d;
    end
  end

  assign pt_ready   = ready_q;
  assign dac_csn    = csn_q;
  assign dac_sclk   = sclk_q;
  assign dac_mosi   = mosi_q;
  assign dac_latchn = latchn_q;
  assign laser_rgb  = laser_q;
  assign wdog_blank = blank_q;
  assign pts_sent   = pts_q;

endmodule
